// File: rtl/gemm_pkg.sv
// Shared GEMM offload definitions: custom opcode, command encodings, buffer
// selects and responder FSM states. The core-side controller imports this too.
package gemm_pkg;

    localparam logic [6:0] GEMM_OPCODE = 7'b0001011;

    typedef enum logic [2:0] {
        CFG_A = 3'b000,
        CFG_B = 3'b001,
        CFG_C = 3'b010,
        START = 3'b011
    } funct3_e;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2
    } mem_sel_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        WAIT    = 3'd4,
        STORE_C = 3'd5,
        DONE    = 3'd6
    } state_e;

    function automatic logic [7:0] clamp_rows(input logic [7:0] req, input logic [7:0] lim);
        if (req > lim) begin
            clamp_rows = lim;
        end else begin
            clamp_rows = req;
        end
    endfunction

endpackage

// File: rtl/gemm_cmd_responder_if.sv
// Core command handshake plus the accelerator's memory-request and array
// control signals; master is the environment, slave is the responder.
interface gemm_cmd_responder_if #(parameter int ADDR_W = 32);

    logic              gemm_valid;
    logic [31:0]       gemm_instruction;
    logic [31:0]       gemm_rdata1;
    logic [31:0]       gemm_rdata2;
    logic              gemm_done;
    logic              gemm_err;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [1:0]        mem_req_sel;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              array_start;
    logic              array_busy;

    modport master (
        output gemm_valid, gemm_instruction, gemm_rdata1, gemm_rdata2,
        output mem_req_ready, array_busy,
        input  gemm_done, gemm_err, mem_req_valid, mem_req_we, mem_req_sel,
        input  mem_req_addr, array_start
    );

    modport slave (
        input  gemm_valid, gemm_instruction, gemm_rdata1, gemm_rdata2,
        input  mem_req_ready, array_busy,
        output gemm_done, gemm_err, mem_req_valid, mem_req_we, mem_req_sel,
        output mem_req_addr, array_start
    );

endinterface

// File: rtl/gemm_row_addr_gen.sv
// Row address accumulator shared by all three memory phases: load restarts
// at a new base/stride, advance steps one row, last flags the final row.
module gemm_row_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [CNT_W-1:0]  rows_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next address/row: accumulation wraps modulo 2^ADDR_W by construction.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            addr_d   = base_i;
            stride_d = stride_i;
            cnt_d    = {CNT_W{1'b0}};
        end else if (adv_i) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q + CNT_W'(1'b1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Address generator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= {ADDR_W{1'b0}};
            stride_q <= {ADDR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == (rows_i - CNT_W'(1'b1)));

endmodule

// File: rtl/gemm_cmd_responder.sv
// Accelerator endpoint for GEMM offload: decodes CFG/START commands, runs the
// A-load, B-load, compute, C-store sequence and returns one done per command.
module gemm_cmd_responder
    import gemm_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    gemm_cmd_responder_if.slave bus
);

    localparam int ROWS_W = $clog2(DIM + 1);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic [ADDR_W-1:0] stride_a_q, stride_a_d, stride_b_q, stride_b_d, stride_c_q, stride_c_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic              done_q, done_d, gerr_q, gerr_d, valid_q, valid_d;
    logic              we_q, we_d, start_q, start_d;
    mem_sel_e          sel_q, sel_d;

    logic              ag_load_s, ag_adv_s, last_s, hs_s, legal_s;
    logic [ADDR_W-1:0] ag_base_s, ag_stride_s, addr_s;
    logic [2:0]        f3_s;
    logic [ROWS_W-1:0] start_rows_s;
    logic              unused_s;

    assign f3_s         = bus.gemm_instruction[14:12];
    assign legal_s      = (bus.gemm_instruction[6:0] == GEMM_OPCODE) && (f3_s[2] == 1'b0);
    assign start_rows_s = ROWS_W'(clamp_rows(bus.gemm_rdata1[7:0], 8'(DIM)));
    assign hs_s         = valid_q & bus.mem_req_ready;
    assign unused_s     = ^{bus.gemm_instruction[31:15], bus.gemm_instruction[11:7],
                            bus.gemm_rdata1[31:8]};

    gemm_row_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(ROWS_W)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ag_load_s),
        .adv_i    (ag_adv_s),
        .base_i   (ag_base_s),
        .stride_i (ag_stride_s),
        .rows_i   (rows_q),
        .addr_o   (addr_s),
        .last_o   (last_s)
    );

    // Next-state, config writes and the address generator is reloaded with the
    // next phase's base on each phase's last accepted row.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        base_a_d   = base_a_q;   stride_a_d = stride_a_q;
        base_b_d   = base_b_q;   stride_b_d = stride_b_q;
        base_c_d   = base_c_q;   stride_c_d = stride_c_q;
        rows_d     = rows_q;
        ag_load_s  = 1'b0;
        ag_adv_s   = 1'b0;
        ag_base_s  = base_a_q;
        ag_stride_s = stride_a_q;
        case (state_q)
            IDLE: begin
                if (bus.gemm_valid && !legal_s) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus.gemm_valid) begin
                    state_d = DONE;
                    case (f3_s)
                        CFG_A: begin base_a_d = bus.gemm_rdata1; stride_a_d = bus.gemm_rdata2; end
                        CFG_B: begin base_b_d = bus.gemm_rdata1; stride_b_d = bus.gemm_rdata2; end
                        CFG_C: begin base_c_d = bus.gemm_rdata1; stride_c_d = bus.gemm_rdata2; end
                        START: begin
                            rows_d = start_rows_s;
                            if (start_rows_s != {ROWS_W{1'b0}}) begin
                                state_d   = LOAD_A;
                                ag_load_s = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A, LOAD_B, STORE_C: begin
                if (hs_s && last_s) begin
                    ag_load_s = 1'b1;
                    case (state_q)
                        LOAD_A: begin
                            state_d     = LOAD_B;
                            ag_base_s   = base_b_q;
                            ag_stride_s = stride_b_q;
                        end
                        LOAD_B: begin
                            state_d     = COMPUTE;
                            ag_base_s   = base_c_q;
                            ag_stride_s = stride_c_q;
                        end
                        default: state_d = DONE;
                    endcase
                end else if (hs_s) begin
                    ag_adv_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            COMPUTE: state_d = WAIT;
            WAIT: begin
                if (bus.array_busy) begin
                    state_d = WAIT;
                end else begin
                    state_d = STORE_C;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        valid_d = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == STORE_C);
        we_d    = (state_d == STORE_C);
        start_d = (state_d == COMPUTE);
        done_d  = (state_d == DONE);
        gerr_d  = (state_d == DONE) && err_d;
        case (state_d)
            LOAD_B:  sel_d = SEL_B;
            STORE_C: sel_d = SEL_C;
            default: sel_d = SEL_A;
        endcase
    end

    // FSM, configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            base_a_q   <= {ADDR_W{1'b0}};  stride_a_q <= {ADDR_W{1'b0}};
            base_b_q   <= {ADDR_W{1'b0}};  stride_b_q <= {ADDR_W{1'b0}};
            base_c_q   <= {ADDR_W{1'b0}};  stride_c_q <= {ADDR_W{1'b0}};
            rows_q     <= {ROWS_W{1'b0}};
            done_q     <= 1'b0;
            gerr_q     <= 1'b0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            sel_q      <= SEL_A;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            base_a_q   <= base_a_d;  stride_a_q <= stride_a_d;
            base_b_q   <= base_b_d;  stride_b_q <= stride_b_d;
            base_c_q   <= base_c_d;  stride_c_q <= stride_c_d;
            rows_q     <= rows_d;
            done_q     <= done_d;
            gerr_q     <= gerr_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            start_q    <= start_d;
            sel_q      <= sel_d;
        end
    end

    assign bus.gemm_done     = done_q;
    assign bus.gemm_err      = gerr_q;
    assign bus.mem_req_valid = valid_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_sel   = sel_q;
    assign bus.mem_req_addr  = addr_s;
    assign bus.array_start   = start_q;

endmodule

// File: tb/tb_gemm_cmd_responder.sv
// Directed bench for gemm_cmd_responder: configuration, full START sequences,
// backpressure, row clamping, illegal commands and mid-sequence reset.
module tb_gemm_cmd_responder;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gemm_cmd_responder_if #(.ADDR_W(32)) bus();

    gemm_cmd_responder #(.DIM(8), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] opc);
        return {17'd0, f3, 5'd0, opc};
    endfunction

    function automatic logic [34:0] ent(input logic [1:0] s, input logic w, input logic [31:0] a);
        return {s, w, a};
    endfunction

    logic [34:0] reqs[$];
    int          start_cnt, done_cnt, a_seen, stall_cnt, stall_bad, bp_left;
    logic [31:0] stall_addr;

    // Monitor: record accepted requests, stalls, start pulses and dones.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                reqs.push_back({bus.mem_req_sel, bus.mem_req_we, bus.mem_req_addr});
                if (bus.mem_req_sel == 2'd0) a_seen++;
            end
            if (bus.mem_req_valid && !bus.mem_req_ready) begin
                stall_cnt++;
                if ({bus.mem_req_sel, bus.mem_req_we, bus.mem_req_addr} !== {2'd0, 1'b0, stall_addr})
                    stall_bad++;
            end
            if (bus.array_start) start_cnt++;
            if (bus.gemm_done) done_cnt++;
        end
    end

    // Memory ready: optionally held low while the second A row is presented.
    always @(posedge clk) begin
        #1;
        if (bp_left > 0 && bus.mem_req_valid && bus.mem_req_sel == 2'd0 && a_seen == 1) begin
            bus.mem_req_ready = 1'b0;
            bp_left--;
        end else begin
            bus.mem_req_ready = 1'b1;
        end
    end

    task automatic run_cmd(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                           output int lat, output logic err);
        reqs.delete();
        start_cnt = 0; done_cnt = 0; a_seen = 0; stall_cnt = 0; stall_bad = 0;
        lat = 0; err = 1'b0;
        @(posedge clk); #1;
        bus.gemm_valid = 1'b1; bus.gemm_instruction = instr;
        bus.gemm_rdata1 = r1;  bus.gemm_rdata2 = r2;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.gemm_done) begin
                lat = n;
                err = bus.gemm_err;
                break;
            end
        end
        @(posedge clk); #1;
        bus.gemm_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic [34:0] exp3[9];
    int          lat;
    logic        err;
    int          n_a, n_b, n_c, seen_start;

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        exp3[0] = ent(2'd0, 1'b0, 32'h1000); exp3[1] = ent(2'd0, 1'b0, 32'h1040);
        exp3[2] = ent(2'd0, 1'b0, 32'h1080); exp3[3] = ent(2'd1, 1'b0, 32'h2000);
        exp3[4] = ent(2'd1, 1'b0, 32'h2040); exp3[5] = ent(2'd1, 1'b0, 32'h2080);
        exp3[6] = ent(2'd2, 1'b1, 32'h3000); exp3[7] = ent(2'd2, 1'b1, 32'h3080);
        exp3[8] = ent(2'd2, 1'b1, 32'h3100);

        rst = 1'b1;
        bus.gemm_valid = 1'b0; bus.gemm_instruction = 32'd0;
        bus.gemm_rdata1 = 32'd0; bus.gemm_rdata2 = 32'd0; bus.array_busy = 1'b0;
        stall_addr = 32'd0; bp_left = 0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {bus.gemm_done, bus.gemm_err, bus.mem_req_valid, bus.mem_req_we,
                  bus.mem_req_sel, bus.array_start, bus.mem_req_addr}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_cmd(mk_instr(3'b000, 7'b0001011), 32'h1000, 32'h40, lat, err);
        check_val("cfg_a_latency", 64'(lat), 64'd1);
        check_val("cfg_a_err", {63'd0, err}, 64'd0);
        check_val("cfg_a_no_req", 64'(reqs.size()), 64'd0);
        check_val("cfg_a_one_done", 64'(done_cnt), 64'd1);
        run_cmd(mk_instr(3'b001, 7'b0001011), 32'h2000, 32'h40, lat, err);
        check_val("cfg_b_latency", 64'(lat), 64'd1);
        run_cmd(mk_instr(3'b010, 7'b0001011), 32'h3000, 32'h80, lat, err);
        check_val("cfg_c_latency", 64'(lat), 64'd1);

        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd3, 32'd0, lat, err);
        check_val("start3_latency", 64'(lat), 64'd12);
        check_val("start3_err", {63'd0, err}, 64'd0);
        check_val("start3_nreq", 64'(reqs.size()), 64'd9);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("start3_req%0d", i), (i < reqs.size()) ? 64'(reqs[i]) : 64'hdead, 64'(exp3[i]));
        check_val("start3_array_start", 64'(start_cnt), 64'd1);
        check_val("start3_one_done", 64'(done_cnt), 64'd1);
        check_val("start3_no_stall", 64'(stall_cnt), 64'd0);

        stall_addr = 32'h1040; bp_left = 4;
        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd3, 32'd0, lat, err);
        check_val("bp_latency", 64'(lat), 64'd16);
        check_val("bp_nreq", 64'(reqs.size()), 64'd9);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("bp_req%0d", i), (i < reqs.size()) ? 64'(reqs[i]) : 64'hdead, 64'(exp3[i]));
        check_val("bp_stall_cycles", 64'(stall_cnt), 64'd4);
        check_val("bp_held_fields", 64'(stall_bad), 64'd0);

        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd20, 32'd0, lat, err);
        n_a = 0; n_b = 0; n_c = 0;
        foreach (reqs[i]) begin
            if (reqs[i][34:33] == 2'd0) n_a++;
            else if (reqs[i][34:33] == 2'd1) n_b++;
            else n_c++;
        end
        check_val("clamp_latency", 64'(lat), 64'd27);
        check_val("clamp_nreq", 64'(reqs.size()), 64'd24);
        check_val("clamp_a_rows", 64'(n_a), 64'd8);
        check_val("clamp_b_rows", 64'(n_b), 64'd8);
        check_val("clamp_c_rows", 64'(n_c), 64'd8);
        check_val("clamp_a_last", (reqs.size() == 24) ? 64'(reqs[7]) : 64'hdead, 64'(ent(2'd0, 1'b0, 32'h11C0)));
        check_val("clamp_c_last", (reqs.size() == 24) ? 64'(reqs[23]) : 64'hdead, 64'(ent(2'd2, 1'b1, 32'h3380)));

        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd0, 32'd0, lat, err);
        check_val("rows0_latency", 64'(lat), 64'd1);
        check_val("rows0_nreq", 64'(reqs.size()), 64'd0);
        check_val("rows0_no_start", 64'(start_cnt), 64'd0);

        run_cmd(mk_instr(3'b111, 7'b0001011), 32'h5555, 32'h10, lat, err);
        check_val("bad_f3_latency", 64'(lat), 64'd1);
        check_val("bad_f3_err", {63'd0, err}, 64'd1);
        check_val("bad_f3_one_done", 64'(done_cnt), 64'd1);
        run_cmd(mk_instr(3'b011, 7'h33), 32'd3, 32'd0, lat, err);
        check_val("bad_opc_err", {63'd0, err}, 64'd1);
        check_val("bad_opc_nreq", 64'(reqs.size()), 64'd0);
        check_val("bad_opc_no_start", 64'(start_cnt), 64'd0);

        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd1, 32'd0, lat, err);
        check_val("cfg_kept_latency", 64'(lat), 64'd6);
        check_val("cfg_kept_err", {63'd0, err}, 64'd0);
        check_val("cfg_kept_a", (reqs.size() == 3) ? 64'(reqs[0]) : 64'hdead, 64'(ent(2'd0, 1'b0, 32'h1000)));
        check_val("cfg_kept_b", (reqs.size() == 3) ? 64'(reqs[1]) : 64'hdead, 64'(ent(2'd1, 1'b0, 32'h2000)));
        check_val("cfg_kept_c", (reqs.size() == 3) ? 64'(reqs[2]) : 64'hdead, 64'(ent(2'd2, 1'b1, 32'h3000)));

        // Reset while the array is busy: command is abandoned.
        reqs.delete(); start_cnt = 0; done_cnt = 0; a_seen = 0; seen_start = 0;
        @(posedge clk); #1;
        bus.array_busy = 1'b1; bus.gemm_valid = 1'b1;
        bus.gemm_instruction = mk_instr(3'b011, 7'b0001011); bus.gemm_rdata1 = 32'd2;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.array_start) begin
                seen_start = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check_val("rst_reached_compute", 64'(seen_start), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_val("rst_async_outputs", {bus.gemm_done, bus.gemm_err, bus.mem_req_valid, bus.mem_req_we,
                  bus.mem_req_sel, bus.array_start, bus.mem_req_addr}, 64'd0);
        bus.gemm_valid = 1'b0; bus.array_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_cmd(mk_instr(3'b011, 7'b0001011), 32'd2, 32'd0, lat, err);
        check_val("post_rst_latency", 64'(lat), 64'd9);
        check_val("post_rst_nreq", 64'(reqs.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("post_rst_req%0d", i), (i < reqs.size()) ? 64'(reqs[i]) : 64'hdead,
                      64'(ent(2'(i / 2), (i >= 4) ? 1'b1 : 1'b0, 32'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
